// File: rtl/score_tracker.sv
// rtl/score_tracker.sv - personal/global best score tracker with registered read port
module score_tracker #(
  parameter int SCORE_W = 7,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               score_req,
  input  logic [SCORE_W-1:0] score_in,
  input  logic [ID_W-1:0]    intPlayID_in,
  input  logic               isGuest_in,
  input  logic               clear_req,
  input  logic [ID_W-1:0]    rd_id,
  output logic               valid,
  output logic               personalwin,
  output logic               globalwin,
  output logic               busy,
  output logic [SCORE_W-1:0] globalBest,
  output logic [ID_W-1:0]    globalID,
  output logic               globalIsGuest,
  output logic [SCORE_W-1:0] rd_best
);

  localparam int N_ENTRIES = 1 << ID_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_COMPARE = 2'd2,
    S_UPDATE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [SCORE_W-1:0] r_best [N_ENTRIES];
  logic [SCORE_W-1:0] r_score;
  logic [ID_W-1:0]    r_id;
  logic               r_guest;
  logic [SCORE_W-1:0] r_pb;
  logic               r_pw;
  logic               r_gw;
  logic               r_valid;
  logic               r_personalwin;
  logic               r_globalwin;
  logic [SCORE_W-1:0] r_gbest;
  logic [ID_W-1:0]    r_gid;
  logic               r_gguest;
  logic [SCORE_W-1:0] r_rd_best;

  logic               w_idle;
  logic               w_accept_clear;
  logic               w_accept_req;

  // clear wins over a simultaneous request; both are only honoured in IDLE
  assign w_idle         = (r_state == S_IDLE);
  assign w_accept_clear = w_idle && clear_req;
  assign w_accept_req   = w_idle && !clear_req && score_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept_req) w_next_state = S_LOOKUP;
      S_LOOKUP:  w_next_state = S_COMPARE;
      S_COMPARE: w_next_state = S_UPDATE;
      S_UPDATE:  w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) r_best[i] <= '0;
      r_score       <= '0;
      r_id          <= '0;
      r_guest       <= 1'b0;
      r_pb          <= '0;
      r_pw          <= 1'b0;
      r_gw          <= 1'b0;
      r_valid       <= 1'b0;
      r_personalwin <= 1'b0;
      r_globalwin   <= 1'b0;
      r_gbest       <= '0;
      r_gid         <= '0;
      r_gguest      <= 1'b0;
      r_rd_best     <= '0;
    end else begin
      r_valid   <= 1'b0;
      // read port samples pre-edge contents, so a same-edge write shows up a cycle later
      r_rd_best <= r_best[rd_id];
      case (r_state)
        S_IDLE: begin
          if (w_accept_clear) begin
            for (int i = 0; i < N_ENTRIES; i++) r_best[i] <= '0;
            r_gbest       <= '0;
            r_gid         <= '0;
            r_gguest      <= 1'b0;
            r_personalwin <= 1'b0;
            r_globalwin   <= 1'b0;
          end else if (w_accept_req) begin
            r_score       <= score_in;
            r_id          <= intPlayID_in;
            r_guest       <= isGuest_in;
            r_personalwin <= 1'b0;
            r_globalwin   <= 1'b0;
          end
        end
        S_LOOKUP: begin
          r_pb <= r_best[r_id];
        end
        S_COMPARE: begin
          r_pw <= !r_guest && (r_score > r_pb);
          r_gw <= (r_score > r_gbest);
        end
        S_UPDATE: begin
          r_valid       <= 1'b1;
          r_personalwin <= r_pw;
          r_globalwin   <= r_gw;
          if (r_pw) r_best[r_id] <= r_score;
          if (r_gw) begin
            r_gbest  <= r_score;
            r_gid    <= r_id;
            r_gguest <= r_guest;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid         = r_valid;
  assign personalwin   = r_personalwin;
  assign globalwin     = r_globalwin;
  assign busy          = !w_idle;
  assign globalBest    = r_gbest;
  assign globalID      = r_gid;
  assign globalIsGuest = r_gguest;
  assign rd_best       = r_rd_best;

endmodule

// File: tb/tb_score_tracker.sv
// tb/tb_score_tracker.sv - scoreboard bench for score_tracker against a behavioural record model
module tb_score_tracker;

  logic       clk;
  logic       rst;
  logic       score_req;
  logic [6:0] score_in;
  logic [2:0] intPlayID_in;
  logic       isGuest_in;
  logic       clear_req;
  logic [2:0] rd_id;
  logic       valid;
  logic       personalwin;
  logic       globalwin;
  logic       busy;
  logic [6:0] globalBest;
  logic [2:0] globalID;
  logic       globalIsGuest;
  logic [6:0] rd_best;

  score_tracker #(.SCORE_W(7), .ID_W(3)) dut (
    .clk(clk), .rst(rst), .score_req(score_req), .score_in(score_in),
    .intPlayID_in(intPlayID_in), .isGuest_in(isGuest_in), .clear_req(clear_req),
    .rd_id(rd_id), .valid(valid), .personalwin(personalwin), .globalwin(globalwin),
    .busy(busy), .globalBest(globalBest), .globalID(globalID),
    .globalIsGuest(globalIsGuest), .rd_best(rd_best)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pw;
    int gw;
    int gb;
    int gid;
    int gg;
  } exp_t;

  exp_t sb[$];
  int   m_best[8];
  int   m_gb;
  int   m_gid;
  int   m_gg;
  int   m_last_pw;
  int   m_last_gw;
  int   n_checks;
  int   n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_best[i] = 0;
    m_gb = 0;
    m_gid = 0;
    m_gg = 0;
  endtask

  // records are "strictly higher replaces"; guests keep no personal record
  task automatic predict(input int s, input int id, input int g, output exp_t e);
    e.pw = (g == 0 && s > m_best[id]) ? 1 : 0;
    e.gw = (s > m_gb) ? 1 : 0;
    if (e.pw == 1) m_best[id] = s;
    if (e.gw == 1) begin
      m_gb = s;
      m_gid = id;
      m_gg = g;
    end
    e.gb = m_gb;
    e.gid = m_gid;
    e.gg = m_gg;
    m_last_pw = e.pw;
    m_last_gw = e.gw;
  endtask

  // mode 0: plain, 1: clear_req during LOOKUP, 2: extra score_req held while busy
  task automatic do_req(input int s, input int id, input int g, input int mode);
    exp_t e;
    @(negedge clk);
    score_in = 7'(s);
    intPlayID_in = 3'(id);
    isGuest_in = 1'(g);
    score_req = 1'b1;
    predict(s, id, g, e);
    sb.push_back(e);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        score_req = 1'b0;
        if (mode == 1) clear_req = 1'b1;
        if (mode == 2) begin
          score_req = 1'b1;
          score_in = 7'd127;
          intPlayID_in = 3'(id ^ 1);
          isGuest_in = 1'b0;
        end
      end
      if (c == 2) clear_req = 1'b0;
      if (c == 4) score_req = 1'b0;
    end
    chk("valid_seen", 32'(sb.size()), 32'd0);
    while (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic check_rd(input int id);
    @(negedge clk);
    rd_id = 3'(id);
    @(negedge clk);
    chk($sformatf("rd_best[%0d]", id), 32'(rd_best), 32'(m_best[id]));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    model_clear();
    chk("clear_gbest", 32'(globalBest), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    score_req = 1'b0;
    score_in = '0;
    intPlayID_in = '0;
    isGuest_in = 1'b0;
    clear_req = 1'b0;
    rd_id = '0;
    model_clear();

    fork
      forever begin
        @(negedge clk);
        if (valid === 1'b1) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got 1 expected 0 at %0t", $time);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("mon_personalwin", 32'(personalwin), 32'(e.pw));
            chk("mon_globalwin", 32'(globalwin), 32'(e.gw));
            chk("mon_globalBest", 32'(globalBest), 32'(e.gb));
            chk("mon_globalID", 32'(globalID), 32'(e.gid));
            chk("mon_globalIsGuest", 32'(globalIsGuest), 32'(e.gg));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pw", 32'(personalwin), 32'd0);
    chk("rst_gw", 32'(globalwin), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gbest", 32'(globalBest), 32'd0);
    chk("rst_gid", 32'(globalID), 32'd0);
    chk("rst_gguest", 32'(globalIsGuest), 32'd0);
    chk("rst_rd_best", 32'(rd_best), 32'd0);

    // latency: busy high the cycle after the request edge, valid three edges later
    @(negedge clk);
    score_in = 7'd25;
    intPlayID_in = 3'd3;
    isGuest_in = 1'b0;
    score_req = 1'b1;
    begin
      exp_t e;
      predict(25, 3, 0, e);
      sb.push_back(e);
    end
    @(negedge clk);
    score_req = 1'b0;
    chk("lat_busy_k", 32'(busy), 32'd1);
    chk("lat_valid_k", 32'(valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("lat_valid_k2", 32'(valid), 32'd0);
    chk("lat_busy_k2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_valid_k3", 32'(valid), 32'd1);
    chk("lat_busy_k3", 32'(busy), 32'd0);
    chk("first_gbest", 32'(globalBest), 32'd25);
    chk("first_gid", 32'(globalID), 32'd3);
    @(negedge clk);
    chk("lat_valid_k4", 32'(valid), 32'd0);
    chk("first_queue_empty", 32'(sb.size()), 32'd0);
    check_rd(3);
    chk("first_rd_best", 32'(rd_best), 32'd25);

    do_req(25, 5, 0, 0);
    chk("tie_pw", 32'(personalwin), 32'd1);
    chk("tie_gw", 32'(globalwin), 32'd0);
    do_req(25, 3, 0, 0);
    chk("same_pw", 32'(personalwin), 32'd0);
    do_req(30, 3, 0, 0);
    chk("new_gbest", 32'(globalBest), 32'd30);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_pw", 32'(personalwin), 32'd1);
      chk("hold_gw", 32'(globalwin), 32'd1);
    end

    do_req(40, 0, 1, 0);
    chk("guest_pw", 32'(personalwin), 32'd0);
    chk("guest_gw", 32'(globalwin), 32'd1);
    chk("guest_gguest", 32'(globalIsGuest), 32'd1);
    check_rd(0);
    chk("guest_no_best", 32'(rd_best), 32'd0);

    // clear and request together: clear wins, no response
    @(negedge clk);
    clear_req = 1'b1;
    score_req = 1'b1;
    score_in = 7'd99;
    intPlayID_in = 3'd1;
    @(negedge clk);
    clear_req = 1'b0;
    score_req = 1'b0;
    model_clear();
    chk("clr_gbest", 32'(globalBest), 32'd0);
    chk("clr_gid", 32'(globalID), 32'd0);
    chk("clr_gguest", 32'(globalIsGuest), 32'd0);
    chk("clr_pw", 32'(personalwin), 32'd0);
    chk("clr_gw", 32'(globalwin), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) check_rd(i);

    do_req(0, 4, 0, 0);
    chk("zero_pw", 32'(personalwin), 32'd0);
    chk("zero_gw", 32'(globalwin), 32'd0);
    do_req(10, 6, 0, 2);
    do_req(20, 2, 0, 1);
    chk("clr_lookup_gbest", 32'(globalBest), 32'd20);
    for (int i = 0; i < 8; i++) check_rd(i);

    // reset while a winning request sits in COMPARE
    @(negedge clk);
    score_in = 7'd50;
    intPlayID_in = 3'd2;
    isGuest_in = 1'b0;
    score_req = 1'b1;
    @(negedge clk);
    score_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_gbest", 32'(globalBest), 32'd0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) check_rd(i);

    for (int n = 0; n < 40; n++) begin
      int s;
      int id;
      int g;
      s = int'($urandom_range(0, 127));
      id = int'($urandom_range(0, 7));
      g = ($urandom_range(0, 3) == 0) ? 1 : 0;
      do_req(s, id, g, int'($urandom_range(0, 2)));
      chk("rnd_pw", 32'(personalwin), 32'(m_last_pw));
      chk("rnd_gw", 32'(globalwin), 32'(m_last_gw));
      check_rd(int'($urandom_range(0, 7)));
      if (n % 13 == 12) do_clear();
    end
    for (int i = 0; i < 8; i++) check_rd(i);

    repeat (6) @(negedge clk);
    chk("final_queue_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
# score_tracker

Score-tracking stage that sits directly downstream of the post-game score checker. Each request carries a player's final score, internal player ID and guest flag. The block compares that score against the player's stored personal best and the stored global best, and answers with a one-cycle `valid` pulse plus win flags. It then commits any new records. Stored records are also exposed through a registered read port for the display/face logic.

## Interface
- `SCORE_W`, default 7: score width in bits; fixed by the game scorer.
- `ID_W`, default 3: internal player ID width; the table holds 2^ID_W = 8 personal-best entries.
- `clk` input, 1 bit: system clock; all state changes on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `score_req` input, 1 bit: request pulse; sampled only in IDLE.
- `score_in` input, SCORE_W bits: final score for the request.
- `intPlayID_in` input, ID_W bits: internal player ID for the request.
- `isGuest_in` input, 1 bit: 1 = guest; guests have no personal record.
- `clear_req` input, 1 bit: wipe all records; accepted only in IDLE.
- `rd_id` input, ID_W bits: read-port player ID.
- `valid` output, 1 bit: one-cycle pulse; the result flags are valid from this cycle on.
- `personalwin` output, 1 bit: score strictly exceeded the requester's personal best.
- `globalwin` output, 1 bit: score strictly exceeded the global best.
- `busy` output, 1 bit: high in every state except IDLE.
- `globalBest` output, SCORE_W bits: current global best score.
- `globalID` output, ID_W bits: ID of the global best holder.
- `globalIsGuest` output, 1 bit: the global best holder was a guest.
- `rd_best` output, SCORE_W bits: personal best of `rd_id`, registered.

## Operation
- Storage: `best[0..7]` (SCORE_W each), `globalBest`, `globalID`, `globalIsGuest`. All are cleared to 0 by `rst` or by an accepted `clear_req`.
- State machine: IDLE → LOOKUP → COMPARE → UPDATE → IDLE.
- **IDLE**
  - `clear_req`=1: zero all storage, drop any simultaneous `score_req`, stay IDLE. `clear_req` has priority.
  - Otherwise, `score_req`=1: latch `score_in`, `intPlayID_in`, `isGuest_in`; clear `personalwin`/`globalwin` to 0; go to LOOKUP.
- **LOOKUP**: `pb_reg <= best[id_latched]`. Go to COMPARE.
- **COMPARE**: compute flags, then go to UPDATE.
  - `pw <= !guest_latched && (score_latched > pb_reg)`.
  - `gw <= score_latched > globalBest`.
  - Comparisons are unsigned and strict: a tie is never a win.
- **UPDATE**: go to IDLE, performing the following in the same edge.
  - `valid <= 1`; `personalwin <= pw`; `globalwin <= gw`.
  - If `pw`: `best[id] <= score`.
  - If `gw`: `globalBest <= score`, `globalID <= id`, `globalIsGuest <= guest`.
  - A guest never writes `best[]`, but can take the global record.
- `valid` returns to 0 on the edge after UPDATE.
- `personalwin`/`globalwin` hold their values until the next accepted request clears them. The upstream checker samples the flags one cycle after it sees `valid`.
- `score_req` or `clear_req` outside IDLE: ignored, no queuing.
- Read port: `rd_best <= best[rd_id]` every cycle, independent of the state machine. A same-edge UPDATE write is not visible until the following cycle.
- Out-of-range states recover to IDLE with no storage write.

## Timing
- Request latency: `score_req` sampled high at edge k → `valid` high during cycle k+3 → k+4 (set at edge k+3).
- After the request, `busy` is high from edge k until edge k+3; IDLE is re-entered at k+3.
- New records are visible on `globalBest` after edge k+3, and via `rd_best` after edge k+4.
- Back-to-back throughput: a new request can be accepted at edge k+4, i.e. 4 cycles per request.
- `clear_req` takes effect at the sampling edge. All outputs read 0 the following cycle, except `rd_best`, which reads 0 one cycle later.
- Reset: `rst` high at any edge, including mid-request, sets the following, and discards the in-flight request without writing.
  - State → IDLE.
  - `valid`, `personalwin`, `globalwin`, `busy` → 0.
  - `globalBest`, `globalID`, `globalIsGuest`, `rd_best` → 0.
  - All `best[]` → 0.

## Test plan
- After reset: request with score=25, id=3, guest=0 → `valid` pulse at k+3, `personalwin`=1, `globalwin`=1, `globalBest`=25, `globalID`=3; later `rd_id`=3 gives `rd_best`=25.
- Continuing: id=5, score=25 → pw=1, gw=0 (tie). Then id=3, score=25 → pw=0, gw=0. Then id=3, score=30 → pw=1, gw=1, `globalBest`=30.
- Guest: guest=1, id=0, score=40 → pw=0, gw=1, `globalIsGuest`=1, `best[0]` stays 0. Then score=0 with an empty table → no wins.
- Flag hold: after a winning request the flags stay 1 for ≥5 idle cycles. A second `score_req` pulsed during `busy` is ignored; `valid` pulses exactly once.
- `clear_req` and `score_req` high together in IDLE → all records 0, no `valid`. `clear_req` during LOOKUP → ignored; the request completes normally.
- `rst` asserted in COMPARE of a would-win request (score=50) → no `valid`, `globalBest`=0, all `best[]`=0, `busy`=0 after the reset edge.
